// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - single-outstanding instruction fetch unit with flush support
module instr_fetch #(
  parameter logic [31:0] BOOT_ADDRESS = 32'h0
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] pc_in,
  input  logic        pc_valid_in,
  output logic        pc_ready_out,
  input  logic        flush_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_gnt_in,
  input  logic        imem_rvalid_in,
  input  logic [31:0] imem_rdata_in,
  output logic        instr_valid_out,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc_out,
  output logic        instr_misaligned_out,
  input  logic        instr_ready_in
);

  // IDLE: nothing in flight; REQ: request asserted awaiting grant;
  // WAIT: granted, awaiting read data; HOLD: instruction presented downstream;
  // DISCARD: flushed while a granted read is still in flight, swallow its data.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_WAIT    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_DISCARD = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] instr_q, instr_d;
  logic        misaligned_q, misaligned_d;

  logic        pc_ready;
  logic        accept;
  logic        pc_misaligned;

  // Acceptance is possible when idle, or when the held instruction leaves this cycle.
  always_comb begin
    pc_ready      = ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && instr_ready_in)) && !flush_in;
    accept        = pc_ready && pc_valid_in;
    pc_misaligned = (pc_in[1:0] != 2'b00);
  end

  // Next-state and datapath update; a misaligned PC bypasses memory and is held directly.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    misaligned_d = misaligned_q;

    if (accept) begin
      addr_d       = pc_in;
      misaligned_d = pc_misaligned;
      if (pc_misaligned) begin
        instr_d = 32'h0;
        state_d = ST_HOLD;
      end else begin
        state_d = ST_REQ;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
        end
        ST_REQ: begin
          if (flush_in) begin
            // A grant in the flush cycle means a response is still owed.
            state_d = imem_gnt_in ? ST_DISCARD : ST_IDLE;
          end else if (imem_gnt_in) begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (flush_in) begin
            state_d = imem_rvalid_in ? ST_IDLE : ST_DISCARD;
          end else if (imem_rvalid_in) begin
            instr_d      = imem_rdata_in;
            misaligned_d = 1'b0;
            state_d      = ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (flush_in || instr_ready_in) begin
            state_d = ST_IDLE;
          end
        end
        ST_DISCARD: begin
          if (imem_rvalid_in) begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers; reset overrides everything and never enters DISCARD.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= ST_IDLE;
      addr_q       <= BOOT_ADDRESS;
      instr_q      <= 32'h0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Outputs are pure decodes of state plus the held registers.
  always_comb begin
    pc_ready_out         = pc_ready;
    imem_req_out         = (state_q == ST_REQ);
    imem_addr_out        = addr_q;
    instr_valid_out      = (state_q == ST_HOLD);
    instr_out            = instr_q;
    instr_pc_out         = addr_q;
    instr_misaligned_out = misaligned_q;
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard testbench for instr_fetch
module tb_instr_fetch;

  localparam logic [31:0] BOOT = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_valid;
  logic        pc_ready;
  logic        flush;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_mis;
  logic        instr_ready;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        mis;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  instr_fetch #(.BOOT_ADDRESS(BOOT)) dut (
    .clk_in              (clk),
    .rst_in              (rst),
    .pc_in               (pc_in),
    .pc_valid_in         (pc_valid),
    .pc_ready_out        (pc_ready),
    .flush_in            (flush),
    .imem_req_out        (imem_req),
    .imem_addr_out       (imem_addr),
    .imem_gnt_in         (imem_gnt),
    .imem_rvalid_in      (imem_rvalid),
    .imem_rdata_in       (imem_rdata),
    .instr_valid_out     (instr_valid),
    .instr_out           (instr),
    .instr_pc_out        (instr_pc),
    .instr_misaligned_out(instr_mis),
    .instr_ready_in      (instr_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Delivery monitor: an instruction is consumed when valid & ready with no flush.
  always @(negedge clk) begin
    if (!rst && instr_valid && instr_ready && !flush) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_delivery", instr, 32'hxxxx_xxxx);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_instr", instr, e.instr);
        chk("sb_pc", instr_pc, e.pc);
        chk("sb_mis", {31'b0, instr_mis}, {31'b0, e.mis});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    rst = 1'b1; pc_in = 32'h0; pc_valid = 1'b0; flush = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0; instr_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_req", {31'b0, imem_req}, 32'd0);
    chk("rst_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_mis", {31'b0, instr_mis}, 32'd0);
    chk("rst_addr", imem_addr, BOOT);
    chk("rst_ipc", instr_pc, BOOT);
    chk("rst_ready", {31'b0, pc_ready}, 32'd1);

    // Minimum-latency fetch of 0x100.
    pc_in = 32'h100; pc_valid = 1'b1;
    exp_q.push_back('{instr: 32'h0050_0093, pc: 32'h100, mis: 1'b0});
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1; #1;
    chk("lat_req", {31'b0, imem_req}, 32'd1);
    chk("lat_addr", imem_addr, 32'h100);
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093; #1;
    chk("lat_wait_req", {31'b0, imem_req}, 32'd0);
    chk("lat_wait_valid", {31'b0, instr_valid}, 32'd0);
    tick();
    imem_rvalid = 1'b0; #1;
    chk("lat_valid", {31'b0, instr_valid}, 32'd1);

    // Downstream stall for five cycles, then back-to-back accept of 0x104.
    for (int i = 0; i < 5; i++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_instr", instr, 32'h0050_0093);
      chk("stall_pc", instr_pc, 32'h100);
      chk("stall_ready", {31'b0, pc_ready}, 32'd0);
      tick();
    end
    instr_ready = 1'b1; pc_valid = 1'b1; pc_in = 32'h104; #1;
    chk("b2b_ready", {31'b0, pc_ready}, 32'd1);
    tick();
    instr_ready = 1'b0; pc_valid = 1'b0; #1;
    chk("b2b_req", {31'b0, imem_req}, 32'd1);
    chk("b2b_addr", imem_addr, 32'h104);
    imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; rd = $urandom; imem_rvalid = 1'b1; imem_rdata = rd;
    exp_q.push_back('{instr: rd, pc: 32'h104, mis: 1'b0});
    tick();
    imem_rvalid = 1'b0; instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Misaligned PC: no memory request, held with zero instruction.
    pc_in = 32'h102; pc_valid = 1'b1;
    exp_q.push_back('{instr: 32'h0, pc: 32'h102, mis: 1'b1});
    tick();
    pc_valid = 1'b0; #1;
    chk("mis_req", {31'b0, imem_req}, 32'd0);
    chk("mis_valid", {31'b0, instr_valid}, 32'd1);
    chk("mis_flag", {31'b0, instr_mis}, 32'd1);
    chk("mis_instr", instr, 32'h0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Grant withheld for four cycles, then flush in REQ.
    pc_in = 32'h300; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("nogrant_req", {31'b0, imem_req}, 32'd1);
      chk("nogrant_addr", imem_addr, 32'h300);
      tick();
    end
    flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("flreq_req", {31'b0, imem_req}, 32'd0);
    chk("flreq_idle", {31'b0, pc_ready}, 32'd1);

    // Flush in WAIT; late data must be swallowed.
    pc_in = 32'h400; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0; #1;
    chk("disc_valid", {31'b0, instr_valid}, 32'd0);
    chk("disc_ready", {31'b0, pc_ready}, 32'd0);
    tick();
    imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_rvalid = 1'b0; #1;
    chk("disc_drop_valid", {31'b0, instr_valid}, 32'd0);
    chk("disc_done_ready", {31'b0, pc_ready}, 32'd1);
    pc_in = 32'h200; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h0002_0213;
    exp_q.push_back('{instr: 32'h0002_0213, pc: 32'h200, mis: 1'b0});
    tick();
    imem_rvalid = 1'b0; #1;
    chk("after_disc_instr", instr, 32'h0002_0213);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;

    // Flush in REQ coincident with grant goes to DISCARD.
    pc_in = 32'h500; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1; flush = 1'b1;
    tick();
    imem_gnt = 1'b0; flush = 1'b0; #1;
    chk("flgnt_ready", {31'b0, pc_ready}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0001;
    tick();
    imem_rvalid = 1'b0; #1;
    chk("flgnt_idle", {31'b0, pc_ready}, 32'd1);

    // Flush in HOLD drops the instruction even with downstream ready.
    pc_in = 32'h600; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0002;
    tick();
    imem_rvalid = 1'b0; flush = 1'b1; instr_ready = 1'b1;
    tick();
    flush = 1'b0; instr_ready = 1'b0; #1;
    chk("flhold_valid", {31'b0, instr_valid}, 32'd0);

    // Reset during WAIT, then a stray response.
    pc_in = 32'h700; pc_valid = 1'b1;
    tick();
    pc_valid = 1'b0; imem_gnt = 1'b1;
    tick();
    imem_gnt = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hBAD0_0003;
    tick();
    imem_rvalid = 1'b0; #1;
    chk("rstw_valid", {31'b0, instr_valid}, 32'd0);
    chk("rstw_addr", imem_addr, BOOT);
    chk("rstw_req", {31'b0, imem_req}, 32'd0);
    chk("rstw_ready", {31'b0, pc_ready}, 32'd1);
    tick(); tick();

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter BOOT_ADDRESS, default 32'h0, is the reset value of imem_addr_out and instr_pc_out.
REQ-002 clk_in  input  1  single clock; all state updates on rising edge.
REQ-003 rst_in  input  1  reset; synchronous, active-high.
REQ-004 pc_in  input  32  fetch address from the PC register block.
REQ-005 pc_valid_in  input  1  pc_in valid.
REQ-006 pc_ready_out  output  1  fetch unit accepts pc_in this cycle.
REQ-007 flush_in  input  1  abort current fetch (branch/trap redirect).
REQ-008 imem_req_out  output  1  memory read request.
REQ-009 imem_addr_out  output  32  memory read address.
REQ-010 imem_gnt_in  input  1  memory accepted request.
REQ-011 imem_rvalid_in  input  1  read data valid.
REQ-012 imem_rdata_in  input  32  read data.
REQ-013 instr_valid_out  output  1  instruction available downstream.
REQ-014 instr_out  output  32  fetched instruction.
REQ-015 instr_pc_out  output  32  address of instr_out.
REQ-016 instr_misaligned_out  output  1  instr_pc_out[1:0] != 0; qualified by instr_valid_out.
REQ-017 instr_ready_in  input  1  downstream consumes instruction.

Function
REQ-018 FSM states SHALL be IDLE, REQ, WAIT, HOLD, DISCARD; at most one memory request outstanding.
REQ-019 pc_ready_out SHALL be 1 when (state==IDLE or (state==HOLD and instr_ready_in)) and flush_in==0.
REQ-020 Handshake pc_valid_in & pc_ready_out SHALL latch pc_in into imem_addr_out and instr_pc_out.
REQ-021 On accept with pc_in[1:0]==0: next state REQ; with pc_in[1:0]!=0: next state HOLD, instr_out=0, instr_misaligned_out=1, no memory request.
REQ-022 imem_req_out SHALL equal 1 exactly in REQ; imem_addr_out stable in REQ.
REQ-023 REQ: imem_gnt_in=1 -> WAIT; else stay.
REQ-024 WAIT: imem_rvalid_in=1 -> capture imem_rdata_in into instr_out, clear instr_misaligned_out, -> HOLD.
REQ-025 instr_valid_out SHALL equal 1 exactly in HOLD; instr_out, instr_pc_out, instr_misaligned_out stable while held.
REQ-026 HOLD: instr_ready_in=1 and no new accept -> IDLE; with simultaneous accept -> per REQ-021 (back-to-back, zero bubble on handshake side).
REQ-027 Minimum latency: accept at cycle N, gnt at N+1, rvalid at N+2 -> instr_valid_out=1 at N+3.
REQ-028 flush_in in REQ with imem_gnt_in=0 -> IDLE; with imem_gnt_in=1 -> DISCARD.
REQ-029 flush_in in WAIT with imem_rvalid_in=0 -> DISCARD; with imem_rvalid_in=1 -> IDLE, data dropped.
REQ-030 flush_in in HOLD -> IDLE regardless of instr_ready_in; instruction not delivered.
REQ-031 DISCARD: imem_rvalid_in=1 -> IDLE, data dropped; flush_in in DISCARD has no further effect.
REQ-032 imem_rvalid_in SHALL be ignored in IDLE, REQ and HOLD.
REQ-033 flush_in in IDLE SHALL only block acceptance for that cycle.

Reset
REQ-034 rst_in=1 SHALL force state IDLE next edge, overriding all other inputs.
REQ-035 Reset values: imem_req_out=0, instr_valid_out=0, instr_out=0, instr_misaligned_out=0, imem_addr_out=instr_pc_out=BOOT_ADDRESS; pc_ready_out=1 from first cycle after reset (flush_in=0).
REQ-036 Reset mid-fetch (REQ/WAIT/DISCARD) SHALL NOT enter DISCARD; a late rvalid after reset is ignored per REQ-032.

Verification
REQ-037 Reset, then pc_in=32'h100 accepted, gnt next cycle, rvalid+rdata=32'h00500093 next -> instr_valid_out=1, instr_out=32'h00500093, instr_pc_out=32'h100, three cycles after accept.
REQ-038 instr_ready_in=0 for 5 cycles in HOLD -> outputs stable, pc_ready_out=0; ready=1 with pc_valid_in, pc_in=32'h104 -> accepted same cycle, imem_req_out=1 next cycle with addr 32'h104.
REQ-039 pc_in=32'h102 -> no imem_req_out, next cycle instr_valid_out=1, instr_misaligned_out=1, instr_out=0.
REQ-040 gnt held 0 for 4 cycles -> imem_req_out stays 1, addr stable; flush_in then -> imem_req_out=0 next cycle, IDLE.
REQ-041 flush_in in WAIT, rvalid 2 cycles later with 32'hDEADBEEF -> instr_valid_out never asserts; next fetch 32'h200 returns its own data.
REQ-042 rst_in in WAIT, then stray rvalid -> ignored, instr_valid_out=0, addr=BOOT_ADDRESS.
